ins_loader: RTL and testbench

- Program-load writer for the 20-bit instruction memory that the fetch stage reads.
- Takes a byte stream over a valid/ready handshake and packs every 3 bytes into one 20-bit instruction word.
- Writes consecutive words through the memory's write port, starting at a given word address.
- Holds the CPU fetch stage off (cpu_hold) for the whole load, then reports completion or an error code.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ins_byte_packer.sv | 70 +++++++
 rtl/ins_loader.sv | 158 +++++++++++++++
 tb/tb_ins_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the instruction width, memory depth, the loader FSM state encoding
// and the error codes reported on the loader's err output.
package cpu_pkg;

    localparam int INS_W      = 20;
    localparam int IMEM_DEPTH = 200;
    localparam int IMEM_AW    = 8;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_WRITE = 2'd2,
        LD_FIN   = 2'd3
    } ld_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_FMT  = 2'd2
    } ld_err_t;

endpackage

// File: rtl/ins_byte_packer.sv
// Packs three bytes into one 20-bit instruction word.
// Byte 0 -> word[7:0], byte 1 -> word[15:8], byte 2 low nibble -> word[19:16].
// The high nibble of byte 2 must be zero; otherwise fmt_err pulses instead of
// word_valid.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        returns the byte index to 0 and empties the assembly register
//   byte_fire    a byte is accepted this cycle (valid && ready upstream)
//   byte_data    the accepted byte
//   word_valid   combinational: third byte accepted and well-formed
//   word         combinational: assembled word, meaningful with word_valid
//   fmt_err      combinational: third byte accepted with a non-zero high nibble
module ins_byte_packer
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             byte_fire,
    input  logic [7:0]       byte_data,
    output logic             word_valid,
    output logic [INS_W-1:0] word,
    output logic             fmt_err
);

    logic [1:0]  idx_q, idx_d;
    logic [15:0] asm_q, asm_d;
    logic        last_byte;

    // The third byte is never stored: the word is presented combinationally
    // in the same cycle the byte is accepted.
    assign last_byte  = byte_fire && (idx_q == 2'd2);
    assign word       = {byte_data[3:0], asm_q};
    assign word_valid = last_byte && (byte_data[7:4] == 4'd0);
    assign fmt_err    = last_byte && (byte_data[7:4] != 4'd0);

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (clear) begin
            idx_d = 2'd0;
            asm_d = 16'd0;
        end else if (byte_fire) begin
            case (idx_q)
                2'd0: begin
                    asm_d[7:0] = byte_data;
                    idx_d      = 2'd1;
                end
                2'd1: begin
                    asm_d[15:8] = byte_data;
                    idx_d       = 2'd2;
                end
                default: begin
                    idx_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            asm_q <= 16'd0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/ins_loader.sv
// Program-load writer for the instruction memory read by the fetch stage.
// A byte stream is packed three bytes per 20-bit word and written to
// consecutive word addresses starting at base_addr. The fetch stage is held
// off (cpu_hold) for the whole load; done pulses at the end and err reports
// the outcome until the next accepted start.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a load (ignored unless idle)
//   base_addr, word_count first address and word count, sampled with start
//   in_valid/in_ready     byte handshake: a byte moves when both are high
//                         in the same cycle; in_ready does not depend on
//                         in_valid and in_data is only used on that cycle
//   in_data               byte stream data
//   mem_we/addr/wdata     memory write port; addr/wdata hold when we is low
//   cpu_hold, busy        high whenever the loader is not idle
//   done                  one-cycle end-of-load pulse
//   err                   0 none, 1 address overflow, 2 format error
module ins_loader
    import cpu_pkg::*;
#(
    parameter int DATA_W = INS_W,
    parameter int ADDR_W = IMEM_AW,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              pk_clear;
    logic              pk_fire;
    logic              pk_word_valid;
    logic              pk_fmt_err;
    logic [INS_W-1:0]  pk_word;
    logic [ADDR_W:0]   end_addr;

    // One bit wider than the address so base + count cannot wrap.
    assign end_addr = {1'b0, base_addr} + {1'b0, word_count};

    ins_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_fire  (pk_fire),
        .byte_data  (in_data),
        .word_valid (pk_word_valid),
        .word       (pk_word),
        .fmt_err    (pk_fmt_err)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        pk_clear    = 1'b0;
        pk_fire     = 1'b0;
        case (state_q)
            LD_IDLE: begin
                pk_clear = 1'b1;
                if (start) begin
                    addr_d = base_addr;
                    cnt_d  = word_count;
                    wr_d   = '0;
                    err_d  = ERR_NONE;
                    if (word_count == '0) begin
                        state_d = LD_FIN;
                    end else if (end_addr > DEPTH_X) begin
                        err_d   = ERR_OVF;
                        state_d = LD_FIN;
                    end else begin
                        state_d = LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                in_ready = 1'b1;
                pk_fire  = in_valid;
                if (pk_fmt_err) begin
                    err_d   = ERR_FMT;
                    state_d = LD_FIN;
                end else if (pk_word_valid) begin
                    // Capture the write beat here so the port holds steady
                    // through WRITE and afterwards.
                    mem_addr_d  = addr_q;
                    mem_wdata_d = DATA_W'(pk_word);
                    state_d     = LD_WRITE;
                end
            end
            LD_WRITE: begin
                mem_we   = 1'b1;
                pk_clear = 1'b1;
                addr_d   = addr_q + 1'b1;
                wr_d     = wr_q + 1'b1;
                state_d  = (wr_d == cnt_q) ? LD_FIN : LD_LOAD;
            end
            default: begin
                done    = 1'b1;
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            err_q       <= ERR_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = (state_q != LD_IDLE);
    assign busy      = cpu_hold;
    assign err       = err_q;

endmodule

// File: tb/tb_ins_loader.sv
module tb_ins_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit in_load = 0;
    bit ready_seen = 0;
    bit prev_ok = 0;
    logic [7:0]  prev_addr;
    logic [19:0] prev_wdata;
    logic [19:0] last_wdata;
    logic [7:0]  last_addr;

    // Expected writes, {addr, data}, in order.
    logic [27:0] exp_q[$];
    logic [7:0]  bq[$];
    int          wr_cyc[$];

    ins_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_eq_hold", busy, cpu_hold);
            if (in_load) chk("hold_during_load", cpu_hold, 1);
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    chk("mem_addr", mem_addr, e[27:20]);
                    chk("mem_wdata", mem_wdata, e[19:0]);
                end
                wr_cyc.push_back(cyc);
                last_wdata = mem_wdata;
                last_addr  = mem_addr;
            end else if (prev_ok) begin
                chk("addr_hold", mem_addr, prev_addr);
                chk("wdata_hold", mem_wdata, prev_wdata);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (in_ready) ready_seen = 1;
        end
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_ok    = rst_n;
    end

    // ---------------- driver tasks ----------------
    // Entered and left at posedge + 1.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        bit ok;
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        if (inj) begin
            start      = 1'b1;
            base_addr  = 8'd0;
            word_count = 8'd0;
        end
        ok = 0;
        t  = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            t++;
        end while (!ok && t < 100);
        in_valid = 1'b0;
        if (!ok) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [7:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(negedge clk);
        start_cyc = cyc;
        chk("hold_before_start", cpu_hold, 0);
        @(posedge clk);
        #1;
        start      = 1'b0;
        in_load    = 1;
        ready_seen = 0;
    endtask

    // Full load against the reference model, using bytes from bq.
    task automatic do_load(input logic [7:0] b, input logic [7:0] c, input int gap, input bit inj);
        int exp_err;
        int nsend;
        int d0;
        int t;
        exp_err = 0;
        nsend   = 0;
        if (c == 0) begin
            exp_err = 0;
        end else if (int'(b) + int'(c) > 200) begin
            exp_err = 1;
        end else begin
            for (int k = 0; k < int'(c); k++) begin
                logic [7:0] b0, b1, b2;
                b0 = bq[3*k];
                b1 = bq[3*k+1];
                b2 = bq[3*k+2];
                nsend = 3*k + 3;
                if (b2[7:4] != 4'd0) begin
                    exp_err = 2;
                    break;
                end
                exp_q.push_back({b + 8'(k), b2[3:0], b1, b0});
            end
        end
        d0 = done_cnt;
        wr_cyc.delete();
        pulse_start(b, c);
        @(negedge clk);
        chk("hold_after_start", cpu_hold, 1);
        chk("err_after_start", err, (exp_err == 1) ? 1 : 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < nsend; i++)
            send_byte(bq[i], gap, inj && (i == 4));
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        in_load = 0;
        chk("done_once", done_cnt - d0, 1);
        chk("done_is_pulse", done, 0);
        chk("hold_released", cpu_hold, 0);
        chk("busy_released", busy, 0);
        chk("err_final", err, exp_err);
        chk("all_writes_seen", exp_q.size(), 0);
        if (nsend == 0) begin
            chk("no_ready_when_skipped", ready_seen, 0);
            if (c == 0) chk("zero_done_latency", done_cyc - start_cyc, 1);
            else        chk("ovf_done_latency_le2", (done_cyc - start_cyc) <= 2, 1);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bytes(input int n, input bit allow_bad);
        bq.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            if ((i % 3) == 2 && !(allow_bad && $urandom_range(0, 5) == 0))
                v[7:4] = 4'd0;
            bq.push_back(v);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = 8'd0;
        word_count = 8'd0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload so the write port holds non-zero values before the reset test.
        fill_bytes(3, 0);
        do_load(8'd5, 8'd1, 0, 0);

        // Reset in the middle of a load after two bytes.
        pulse_start(8'd5, 8'd2);
        send_byte(8'h5A, 0, 0);
        send_byte(8'hA5, 0, 0);
        rst_n = 1'b0;
        #1;
        in_load = 0;
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known word after reset.
        bq = '{8'h11, 8'h22, 8'h03};
        do_load(8'd0, 8'd1, 0, 0);
        chk("known_wdata", last_wdata, 20'h32211);
        chk("known_addr", last_addr, 0);

        // Back-to-back stream: one write every 4 cycles.
        fill_bytes(9, 0);
        do_load(8'd10, 8'd3, 0, 0);
        chk("spacing_count", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3) begin
            chk("spacing_1", wr_cyc[1] - wr_cyc[0], 4);
            chk("spacing_2", wr_cyc[2] - wr_cyc[1], 4);
        end
        chk("last_addr_12", last_addr, 12);

        // Address overflow.
        do_load(8'd198, 8'd3, 0, 0);

        // Format error, then a clean start clears err.
        bq = '{8'hAA, 8'hBB, 8'h1C};
        do_load(8'd0, 8'd1, 0, 0);
        do_load(8'd20, 8'd0, 0, 0);

        // Exact fit at the top of memory.
        fill_bytes(6, 0);
        do_load(8'd198, 8'd2, 0, 0);

        // Throttled stream with an extra start pulse mid-load.
        fill_bytes(12, 0);
        do_load(8'd30, 8'd4, 2, 1);

        // Random loads.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] rb, rc;
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 199)) : 8'($urandom_range(0, 150));
            rc = 8'($urandom_range(0, 6));
            fill_bytes(3 * int'(rc), 1);
            do_load(rb, rc, $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
